// File: rtl/muldiv_if.sv
// muldiv_if: operand, MTHI/MTLO and result bundle between EX control and the multiply/divide unit.
interface muldiv_if #(parameter int WIDTH = 32);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  modport master (output start, op, A, B, hi_we, lo_we, wdata,
                  input  busy, done, div_zero, hi, lo);
  modport slave  (input  start, op, A, B, hi_we, lo_we, wdata,
                  output busy, done, div_zero, hi, lo);
endinterface

// File: rtl/muldiv.sv
// muldiv: iterative radix-2 MULT/MULTU/DIV/DIVU with architectural HI/LO and MTHI/MTLO.
// Define MULDIV_FAST_MUL_EN for single-cycle MULT/MULTU; divides stay iterative.
module muldiv #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic     clk,
  input  logic     rstn,
  muldiv_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_div, r_neg_q, r_neg_r, r_bz;
  logic [WIDTH-1:0]   r_a, r_b, r_quo, r_rem, r_hi, r_lo;
  logic [2*WIDTH-1:0] r_acc;
  logic               r_busy, r_done, r_dz;
  logic               w_a_neg, w_b_neg, w_ge, w_last;
  logic [WIDTH-1:0]   w_am, w_bm, w_quo_next, w_rem_next, w_quo, w_rem;
  logic [WIDTH:0]     w_sum, w_sh, w_sub;
  logic [2*WIDTH-1:0] w_acc_next, w_prod;
  assign w_a_neg    = ~bus.op[0] & bus.A[WIDTH-1];
  assign w_b_neg    = ~bus.op[0] & bus.B[WIDTH-1];
  assign w_am       = w_a_neg ? -bus.A : bus.A;
  assign w_bm       = w_b_neg ? -bus.B : bus.B;
  assign w_sum      = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_a} : '0);
  assign w_acc_next = {w_sum, r_acc[WIDTH-1:1]};
  // Partial remainder never exceeds the divisor, so the borrow bit alone decides restore.
  assign w_sh       = {r_rem, r_quo[WIDTH-1]};
  assign w_sub      = w_sh - {1'b0, r_b};
  assign w_ge       = ~w_sub[WIDTH];
  assign w_rem_next = w_ge ? w_sub[WIDTH-1:0] : w_sh[WIDTH-1:0];
  assign w_quo_next = {r_quo[WIDTH-2:0], w_ge};
  assign w_prod     = r_neg_q ? -w_acc_next : w_acc_next;
  assign w_quo      = r_neg_q ? -w_quo_next : w_quo_next;
  assign w_rem      = r_neg_r ? -w_rem_next : w_rem_next;
  assign w_last     = r_cnt == CNT_W'(WIDTH - 1);
`ifdef MULDIV_FAST_MUL_EN
  logic [2*WIDTH-1:0] w_fast;
  assign w_fast = bus.op[0] ? {{WIDTH{1'b0}}, bus.A} * {{WIDTH{1'b0}}, bus.B}
                            : $unsigned($signed({{WIDTH{bus.A[WIDTH-1]}}, bus.A}) *
                                        $signed({{WIDTH{bus.B[WIDTH-1]}}, bus.B}));
`endif
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_div   <= 1'b0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_bz    <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_quo   <= '0;
      r_rem   <= '0;
      r_acc   <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_dz    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_dz    <= 1'b0;
            r_div   <= bus.op[1];
            r_neg_q <= w_a_neg ^ w_b_neg;
            r_neg_r <= w_a_neg;
            r_bz    <= bus.B == '0;
            r_a     <= w_am;
            r_b     <= w_bm;
            r_quo   <= w_am;
            r_rem   <= '0;
            r_acc   <= {{WIDTH{1'b0}}, w_bm};
            r_cnt   <= '0;
            r_busy  <= 1'b1;
`ifdef MULDIV_FAST_MUL_EN
            if (!bus.op[1]) begin
              r_state      <= DONE;
              r_done       <= 1'b1;
              {r_hi, r_lo} <= w_fast;
            end else begin
              r_state <= RUN;
            end
`else
            r_state <= RUN;
`endif
          end else begin
            if (bus.hi_we) r_hi <= bus.wdata;
            if (bus.lo_we) r_lo <= bus.wdata;
          end
        end
        RUN: begin
          r_cnt <= r_cnt + 1'b1;
          r_acc <= w_acc_next;
          r_quo <= w_quo_next;
          r_rem <= w_rem_next;
          if (w_last) begin
            r_state <= DONE;
            r_done  <= 1'b1;
            if (!r_div) {r_hi, r_lo} <= w_prod;
            else if (r_bz) r_dz <= 1'b1;
            else begin
              r_hi <= w_rem;
              r_lo <= w_quo;
            end
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.div_zero = r_dz;
  assign bus.hi       = r_hi;
  assign bus.lo       = r_lo;
endmodule

// File: tb/tb_muldiv.sv
// tb_muldiv: scoreboard bench for muldiv; expected HI/LO/div_zero/latency come from a reference model.
module tb_muldiv;
  logic clk = 1'b0;
  logic rstn = 1'b1;
  always #5 clk = ~clk;
  muldiv_if bus ();
  muldiv dut (.clk(clk), .rstn(rstn), .bus(bus));
`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif
  typedef struct packed {logic [31:0] hi; logic [31:0] lo; logic dz; int lat;} exp_t;
  typedef struct packed {logic [1:0] op; logic [31:0] a; logic [31:0] b; logic [31:0] hi; logic [31:0] lo;} vec_t;
  exp_t sb[$];
  int n_run = 0, n_fail = 0;
  logic [31:0] m_hi = '0, m_lo = '0;

  function automatic exp_t model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    logic signed [63:0] xa, xb, q, r;
    logic [63:0] p;
    xa = $signed(a);
    xb = $signed(b);
    e.dz = 1'b0;
    e.lat = op[1] ? 33 : MUL_LAT;
    p = {m_hi, m_lo};
    if (op == 2'd0) p = xa * xb;
    else if (op == 2'd1) p = {32'b0, a} * {32'b0, b};
    else if (b == 32'd0) e.dz = 1'b1;
    else if (op == 2'd2) begin
      q = xa / xb;
      r = xa % xb;
      p = {r[31:0], q[31:0]};
    end else p = {a % b, a / b};
    {m_hi, m_lo} = p;
    e.hi = p[63:32];
    e.lo = p[31:0];
    return e;
  endfunction

  task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input bit lo_with,
                       output logic [31:0] hi, output logic [31:0] lo, output logic dz, output int lat, output int bcnt);
    @(posedge clk); #1;
    bus.start = 1'b1; bus.op = op; bus.A = a; bus.B = b;
    bus.lo_we = lo_with; bus.wdata = 32'h5555_5555;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.lo_we = 1'b0;
    bus.op = 2'($urandom); bus.A = $urandom; bus.B = $urandom;
    lat = 0; bcnt = 0; hi = '0; lo = '0; dz = 1'b0;
    for (int i = 1; i <= 100; i++) begin
      if (bus.busy) bcnt++;
      if (bus.done) begin
        lat = i; hi = bus.hi; lo = bus.lo; dz = bus.div_zero;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rstn = 1'b1;
    #2 rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_run++;
    if ({bus.busy, bus.done, bus.div_zero, bus.hi, bus.lo} !== 67'd0) begin
      n_fail++;
      $display("FAIL reset: busy=%b done=%b dz=%b hi=%h lo=%h, exp all zero", bus.busy, bus.done, bus.div_zero, bus.hi, bus.lo);
    end
    rstn = 1'b1;
  endtask

  task automatic test_mul();
    vec_t v[4] = '{'{2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001},
                   '{2'd0, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB},
                   '{2'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000},
                   '{2'd1, 32'h00000000, 32'h00001234, 32'h00000000, 32'h00000000}};
    exp_t e; logic [31:0] hi, lo; logic dz; int lat, bcnt;
    foreach (v[i]) begin
      e = model(v[i].op, v[i].a, v[i].b);
      e.hi = v[i].hi; e.lo = v[i].lo;
      sb.push_back(e);
      do_op(v[i].op, v[i].a, v[i].b, 1'b0, hi, lo, dz, lat, bcnt);
      e = sb.pop_front();
      n_run++;
      if ({hi, lo, dz, lat} !== {e.hi, e.lo, e.dz, e.lat}) begin
        n_fail++;
        $display("FAIL mul[%0d]: got hi=%h lo=%h dz=%b lat=%0d, exp hi=%h lo=%h dz=%b lat=%0d", i, hi, lo, dz, lat, e.hi, e.lo, e.dz, e.lat);
      end
      n_run++;
      if (bcnt !== e.lat) begin
        n_fail++;
        $display("FAIL mul_busy[%0d]: busy cycles %0d, exp %0d", i, bcnt, e.lat);
      end
    end
  endtask

  task automatic test_div();
    vec_t v[5] = '{'{2'd2, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD},
                   '{2'd3, 32'hFFFFFFF9, 32'd2,        32'h00000001, 32'h7FFFFFFC},
                   '{2'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000},
                   '{2'd2, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD},
                   '{2'd3, 32'd100,      32'd7,        32'h00000002, 32'h0000000E}};
    exp_t e; logic [31:0] hi, lo; logic dz; int lat, bcnt;
    foreach (v[i]) begin
      e = model(v[i].op, v[i].a, v[i].b);
      e.hi = v[i].hi; e.lo = v[i].lo;
      sb.push_back(e);
      do_op(v[i].op, v[i].a, v[i].b, 1'b0, hi, lo, dz, lat, bcnt);
      e = sb.pop_front();
      n_run++;
      if ({hi, lo, dz, lat, bcnt} !== {e.hi, e.lo, e.dz, e.lat, e.lat}) begin
        n_fail++;
        $display("FAIL div[%0d]: got hi=%h lo=%h dz=%b lat=%0d busy=%0d, exp hi=%h lo=%h dz=%b lat=%0d", i, hi, lo, dz, lat, bcnt, e.hi, e.lo, e.dz, e.lat);
      end
    end
  endtask

  task automatic test_divzero();
    exp_t e; logic [31:0] hi, lo; logic dz; int lat, bcnt;
    logic [1:0] ops[3] = '{2'd3, 2'd2, 2'd3};
    logic [31:0] bs[3] = '{32'd0, 32'd0, 32'd3};
    @(posedge clk); #1 bus.hi_we = 1'b1; bus.wdata = 32'h11;
    @(posedge clk); #1 bus.hi_we = 1'b0; bus.lo_we = 1'b1; bus.wdata = 32'h22;
    @(posedge clk); #1 bus.lo_we = 1'b0;
    m_hi = 32'h11; m_lo = 32'h22;
    n_run++;
    if ({bus.hi, bus.lo} !== {32'h11, 32'h22}) begin
      n_fail++;
      $display("FAIL preload: got hi=%h lo=%h, exp hi=11 lo=22", bus.hi, bus.lo);
    end
    foreach (ops[i]) begin
      sb.push_back(model(ops[i], 32'd5 + 32'(i * 4), bs[i]));
      do_op(ops[i], 32'd5 + 32'(i * 4), bs[i], 1'b0, hi, lo, dz, lat, bcnt);
      e = sb.pop_front();
      n_run++;
      if ({hi, lo, dz, lat} !== {e.hi, e.lo, e.dz, e.lat}) begin
        n_fail++;
        $display("FAIL divzero[%0d]: got hi=%h lo=%h dz=%b lat=%0d, exp hi=%h lo=%h dz=%b lat=%0d", i, hi, lo, dz, lat, e.hi, e.lo, e.dz, e.lat);
      end
    end
  endtask

  task automatic test_mtlo();
    exp_t e; logic [31:0] hi, lo, prev; logic dz; int lat, bcnt;
    @(posedge clk); #1 bus.lo_we = 1'b1; bus.wdata = 32'hABCD;
    @(posedge clk); #1 bus.lo_we = 1'b0;
    m_lo = 32'hABCD;
    n_run++;
    if (bus.lo !== 32'hABCD) begin
      n_fail++;
      $display("FAIL mtlo: got lo=%h, exp lo=0000abcd", bus.lo);
    end
    bus.hi_we = 1'b1; bus.lo_we = 1'b1; bus.wdata = 32'h600D;
    @(posedge clk); #1 bus.hi_we = 1'b0; bus.lo_we = 1'b0;
    m_hi = 32'h600D; m_lo = 32'h600D;
    n_run++;
    if ({bus.hi, bus.lo} !== {32'h600D, 32'h600D}) begin
      n_fail++;
      $display("FAIL mthi_mtlo: got hi=%h lo=%h, exp both 0000600d", bus.hi, bus.lo);
    end
    prev = m_hi;
    sb.push_back(model(2'd3, 32'd100, 32'd7));
    @(posedge clk); #1 bus.start = 1'b1; bus.op = 2'd3; bus.A = 32'd100; bus.B = 32'd7;
    @(posedge clk); #1 bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #1 bus.hi_we = 1'b1; bus.wdata = 32'hDEAD; bus.start = 1'b1; bus.op = 2'd1; bus.A = 32'd1; bus.B = 32'd1;
    @(posedge clk); #1 bus.hi_we = 1'b0; bus.start = 1'b0;
    n_run++;
    if (bus.hi !== prev) begin
      n_fail++;
      $display("FAIL mthi_in_run: got hi=%h, exp hi=%h", bus.hi, prev);
    end
    lat = 6;
    for (int i = 0; i < 100 && !bus.done; i++) begin
      @(posedge clk); #1;
      lat++;
    end
    e = sb.pop_front();
    n_run++;
    if ({bus.hi, bus.lo, bus.div_zero, lat} !== {e.hi, e.lo, e.dz, e.lat}) begin
      n_fail++;
      $display("FAIL run_ignore: got hi=%h lo=%h dz=%b lat=%0d, exp hi=%h lo=%h dz=%b lat=%0d", bus.hi, bus.lo, bus.div_zero, lat, e.hi, e.lo, e.dz, e.lat);
    end
    sb.push_back(model(2'd1, 32'd3, 32'd5));
    do_op(2'd1, 32'd3, 32'd5, 1'b1, hi, lo, dz, lat, bcnt);
    e = sb.pop_front();
    n_run++;
    if ({hi, lo, dz, lat} !== {e.hi, e.lo, e.dz, e.lat}) begin
      n_fail++;
      $display("FAIL start_lo_we: got hi=%h lo=%h dz=%b lat=%0d, exp hi=%h lo=%h dz=%b lat=%0d", hi, lo, dz, lat, e.hi, e.lo, e.dz, e.lat);
    end
  endtask

  task automatic test_abort();
    exp_t e; logic [31:0] hi, lo; logic dz; int lat, bcnt;
    @(posedge clk); #1 bus.hi_we = 1'b1; bus.lo_we = 1'b1; bus.wdata = 32'h77;
    @(posedge clk); #1 bus.hi_we = 1'b0; bus.lo_we = 1'b0;
    bus.start = 1'b1; bus.op = 2'd2; bus.A = 32'hFFFFFFF9; bus.B = 32'd2;
    @(posedge clk); #1 bus.start = 1'b0;
    repeat (9) @(posedge clk);
    #1 rstn = 1'b0;
    #1;
    n_run++;
    if ({bus.busy, bus.done, bus.div_zero, bus.hi, bus.lo} !== 67'd0) begin
      n_fail++;
      $display("FAIL abort: busy=%b done=%b dz=%b hi=%h lo=%h, exp all zero", bus.busy, bus.done, bus.div_zero, bus.hi, bus.lo);
    end
    @(posedge clk); #1 rstn = 1'b1;
    m_hi = '0; m_lo = '0;
    repeat (3) @(posedge clk);
    #1;
    n_run++;
    if ({bus.busy, bus.done} !== 2'b00) begin
      n_fail++;
      $display("FAIL abort_idle: busy=%b done=%b, exp 0 0", bus.busy, bus.done);
    end
    sb.push_back(model(2'd0, 32'hFFFFFFFD, 32'd7));
    do_op(2'd0, 32'hFFFFFFFD, 32'd7, 1'b0, hi, lo, dz, lat, bcnt);
    e = sb.pop_front();
    n_run++;
    if ({hi, lo, dz, lat} !== {e.hi, e.lo, e.dz, e.lat}) begin
      n_fail++;
      $display("FAIL after_abort: got hi=%h lo=%h dz=%b lat=%0d, exp hi=%h lo=%h dz=%b lat=%0d", hi, lo, dz, lat, e.hi, e.lo, e.dz, e.lat);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e; logic [31:0] hi, lo, a, b; logic [1:0] op; logic dz; int lat, bcnt;
    for (int i = 0; i < 8; i++) begin
      op = 2'($urandom);
      a = $urandom;
      b = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom;
      sb.push_back(model(op, a, b));
      do_op(op, a, b, 1'b0, hi, lo, dz, lat, bcnt);
      e = sb.pop_front();
      n_run++;
      if ({hi, lo, dz, lat, bcnt} !== {e.hi, e.lo, e.dz, e.lat, e.lat}) begin
        n_fail++;
        $display("FAIL b2b[%0d] op=%0d a=%h b=%h: got hi=%h lo=%h dz=%b lat=%0d busy=%0d, exp hi=%h lo=%h dz=%b lat=%0d", i, op, a, b, hi, lo, dz, lat, bcnt, e.hi, e.lo, e.dz, e.lat);
      end
    end
    @(posedge clk); #1;
    n_run++;
    if ({bus.busy, bus.done} !== 2'b00) begin
      n_fail++;
      $display("FAIL b2b_idle: busy=%b done=%b, exp 0 0", bus.busy, bus.done);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus.start = 1'b0; bus.op = 2'd0; bus.A = '0; bus.B = '0;
    bus.hi_we = 1'b0; bus.lo_we = 1'b0; bus.wdata = '0;
    test_reset();
    test_mul();
    test_div();
    test_divzero();
    test_mtlo();
    test_abort();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
